instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 87 ++++++++
 tb/tb_instr_encoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS operations into 32-bit words and queues {instr, addr} in a FIFO
module instr_encoder #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [6:0]               in_order,
   input  logic [4:0]               in_rs,
   input  logic [4:0]               in_rt,
   input  logic [4:0]               in_rd,
   input  logic [15:0]              in_imm,
   input  logic [25:0]              in_target,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_addr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic [31:0]   addr_q;
   logic          err_q;
   logic [31:0]   enc_word;
   logic          illegal;
   logic          push, pop;
   assign in_ready  = count_q != FULL;
   assign out_valid = count_q != '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_instr = out_valid ? mem_q[rd_ptr_q][63:32] : '0;
   assign out_addr  = out_valid ? mem_q[rd_ptr_q][31:0] : '0;
   assign count     = count_q;
   assign err       = err_q;
   // Encode the request; unused fields never reach the word, illegal orders encode as zero
   always_comb begin
      enc_word = '0;
      illegal  = 1'b0;
      case (in_order)
         7'd0:    enc_word = '0;
         7'd1:    enc_word = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd33};
         7'd2:    enc_word = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd35};
         7'd3:    enc_word = {6'd13, in_rs, in_rt, in_imm};
         7'd4:    enc_word = {6'd15, 5'd0, in_rt, in_imm};
         7'd5:    enc_word = {6'd35, in_rs, in_rt, in_imm};
         7'd6:    enc_word = {6'd43, in_rs, in_rt, in_imm};
         7'd7:    enc_word = {6'd4, in_rs, in_rt, in_imm};
         7'd8:    enc_word = {6'd2, in_target};
         7'd9:    enc_word = {6'd3, in_target};
         7'd10:   enc_word = {6'd0, in_rs, 15'd0, 6'd8};
         default: illegal  = 1'b1;
      endcase
   end
   // Occupancy follows the net effect of enqueue and dequeue
   always_comb begin
      count_d = (push && !pop) ? count_q + (AW+1)'(1) :
                (pop && !push) ? count_q - (AW+1)'(1) : count_q;
   end
   // Control state: pointers, occupancy, address counter and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= BASE_ADDR;
         err_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            addr_q   <= addr_q + 32'd4;
            err_q    <= err_q | illegal;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end
   // Storage holds the word computed at enqueue time alongside its address
   always_ff @(posedge clk) begin
      if (push && !reset) mem_q[wr_ptr_q] <= {enc_word, addr_q};
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table vectors, corner sequences and random traffic against a queue model
module tb_instr_encoder;
   localparam int DEPTH = 4;
   localparam logic [31:0] BASE = 32'h0000_3000;
   logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [6:0] in_order = '0;
   logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0;
   logic [15:0] in_imm = '0;
   logic [25:0] in_target = '0;
   logic in_ready, out_valid, err, in_ready2, out_valid2, err2;
   logic [31:0] out_instr, out_addr, out_instr2, out_addr2;
   logic [$clog2(DEPTH):0] count, count2;
   int n_cmp = 0, n_bad = 0;
   logic [63:0] q[$];
   logic [31:0] m_addr;
   logic m_err;

   instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_order(in_order), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
      .count(count), .err(err));

   instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .in_order(in_order), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid2),
      .out_ready(out_ready), .out_instr(out_instr2), .out_addr(out_addr2),
      .count(count2), .err(err2));

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  o;
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] tg;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc(input logic [6:0] o, input logic [31:0] rs, rt, rd, imm, tg);
      logic [31:0] r3 = (rs << 21) | (rt << 16) | (rd << 11);
      logic [31:0] ri = (rs << 21) | (rt << 16) | imm;
      case (o)
         7'd1:    return r3 | 32'd33;
         7'd2:    return r3 | 32'd35;
         7'd3:    return (32'd13 << 26) | ri;
         7'd4:    return (32'd15 << 26) | (rt << 16) | imm;
         7'd5:    return (32'd35 << 26) | ri;
         7'd6:    return (32'd43 << 26) | ri;
         7'd7:    return (32'd4 << 26) | ri;
         7'd8:    return (32'd2 << 26) | tg;
         7'd9:    return (32'd3 << 26) | tg;
         7'd10:   return (rs << 21) | 32'd8;
         default: return 32'd0;
      endcase
   endfunction

   task automatic rand_fields();
      in_order = 7'($urandom_range(0, 10));
      if ($urandom_range(0, 9) == 0) in_order = 7'($urandom_range(11, 127));
      in_rs = 5'($urandom);
      in_rt = 5'($urandom);
      in_rd = 5'($urandom);
      in_imm = 16'($urandom);
      in_target = 26'($urandom);
   endtask

   task automatic cyc(input bit do_chk);
      bit deq, enq;
      if (do_chk) begin
         chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("out_instr", 64'(out_instr), q.size() != 0 ? 64'(q[0][63:32]) : 64'd0);
         chk("out_addr", 64'(out_addr), q.size() != 0 ? 64'(q[0][31:0]) : 64'd0);
         chk("count", 64'(count), 64'(q.size()));
         chk("err", 64'(err), 64'(m_err));
      end
      deq = q.size() > 0 && out_ready;
      enq = in_valid && q.size() < DEPTH;
      @(posedge clk);
      if (reset) begin
         q.delete();
         m_addr = BASE;
         m_err = 1'b0;
      end else begin
         if (deq) void'(q.pop_front());
         if (enq) begin
            q.push_back({enc(in_order, 32'(in_rs), 32'(in_rt), 32'(in_rd), 32'(in_imm), 32'(in_target)), m_addr});
            m_addr += 32'd4;
            if (in_order > 7'd10) m_err = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] a2[3];
      vt[0]  = '{7'd1,  5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF, 32'h0022_1821};
      vt[1]  = '{7'd3,  5'd0,  5'd1,  5'd9,  16'h1234, 26'h1,       32'h3401_1234};
      vt[2]  = '{7'd4,  5'd31, 5'd2,  5'd7,  16'hABCD, 26'h5,       32'h3C02_ABCD};
      vt[3]  = '{7'd8,  5'd3,  5'd4,  5'd5,  16'h7777, 26'h0C00,    32'h0800_0C00};
      vt[4]  = '{7'd2,  5'd4,  5'd5,  5'd6,  16'h0001, 26'h0,       32'h0085_3023};
      vt[5]  = '{7'd10, 5'd31, 5'd7,  5'd9,  16'h5555, 26'h2AAAAAA, 32'h03E0_0008};
      vt[6]  = '{7'd50, 5'd1,  5'd1,  5'd1,  16'h1111, 26'h1111,    32'h0000_0000};
      vt[7]  = '{7'd5,  5'd29, 5'd8,  5'd1,  16'hFFFC, 26'h0,       32'h8FA8_FFFC};
      vt[8]  = '{7'd6,  5'd29, 5'd9,  5'd2,  16'h0004, 26'h0,       32'hAFA9_0004};
      vt[9]  = '{7'd7,  5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h0,       32'h1022_FFFF};
      vt[10] = '{7'd9,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0FFF_FFFF};
      vt[11] = '{7'd0,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0000_0000};
      vt[12] = '{7'd4,  5'd0,  5'd2,  5'd0,  16'h0000, 26'h0,       32'h3C02_0000};
      @(negedge clk);
      cyc(0);
      reset = 1'b0;
      // table vectors: push one, see it next cycle, pop it
      for (int i = 0; i < 13; i++) begin
         in_order = vt[i].o; in_rs = vt[i].rs; in_rt = vt[i].rt; in_rd = vt[i].rd;
         in_imm = vt[i].imm; in_target = vt[i].tg;
         in_valid = 1'b1; out_ready = 1'b1;
         cyc(1);
         in_valid = 1'b0;
         chk("vec_instr", 64'(out_instr), 64'(vt[i].exp));
         chk("vec_addr", 64'(out_addr), 64'(BASE + 32'(4 * i)));
         cyc(1);
      end
      chk("err_sticky", 64'(err), 64'd1);
      // full FIFO: 4 pushes stall, 5th held until a dequeue
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_fields();
         in_order = 7'(i + 1);
         cyc(1);
      end
      rand_fields();
      in_order = 7'd7;
      chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(in_ready), 64'd0);
      cyc(1);
      cyc(1);
      out_ready = 1'b1;
      chk("full_ready_oready", 64'(in_ready), 64'd0);
      cyc(1);
      chk("after_deq_count", 64'(count), 64'd3);
      chk("after_deq_ready", 64'(in_ready), 64'd1);
      cyc(1);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) cyc(1);
      chk("drained", 64'(count), 64'd0);
      // reset with entries queued and a handshake pending
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_fields();
         in_order = i == 1 ? 7'd99 : 7'd1;
         cyc(1);
      end
      chk("pre_reset_err", 64'(err), 64'd1);
      out_ready = 1'b1;
      do_reset();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      in_valid = 1'b1;
      rand_fields();
      cyc(1);
      in_valid = 1'b0;
      chk("rst_addr", 64'(out_addr), 64'h0000_3000);
      cyc(1);
      // address wrap on the second instance
      do_reset();
      a2[0] = 32'hFFFF_FFF8; a2[1] = 32'hFFFF_FFFC; a2[2] = 32'h0000_0000;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_fields();
         cyc(1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("wrap_addr", 64'(out_addr2), 64'(a2[i]));
         cyc(1);
      end
      chk("wrap_empty", 64'(out_valid2), 64'd0);
      // random traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rand_fields();
         in_valid = $urandom_range(0, 9) < 7;
         out_ready = $urandom_range(0, 9) < 5;
         reset = $urandom_range(0, 99) == 0;
         cyc(1);
      end
      reset = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
